// File: rtl/kdtree_pkg.sv
// Shared KD-tree definitions: node field layout, Wishbone window constants,
// the slave FSM state type and small decode helpers.
package kdtree_pkg;

  localparam int unsigned KD_DATA_WIDTH = 11;
  localparam int unsigned KD_NUM_NODES  = 63;
  localparam int unsigned KD_NODE_AW    = 6;

  // Byte address of the node-loader window and the STATUS register offset in it
  localparam logic [31:0] WBS_NODE_ADDR = 32'h3000_0000;
  localparam logic [31:0] STATUS_OFF    = 32'h0000_0000;

  typedef struct packed {
    logic [KD_DATA_WIDTH-1:0] median;
    logic [KD_DATA_WIDTH-1:0] idx;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } wbs_state_e;

  // Split the low bits of a bus word into {median, idx}
  function automatic node_t decode_node(input logic [2*KD_DATA_WIDTH-1:0] dat);
    node_t n;
    n.idx    = dat[KD_DATA_WIDTH-1:0];
    n.median = dat[2*KD_DATA_WIDTH-1:KD_DATA_WIDTH];
    return n;
  endfunction

  // STATUS read word: load_done in bit 1, node count starting at bit 8
  function automatic logic [31:0] status_word(input logic [KD_NODE_AW-1:0] count,
                                              input logic done);
    return (32'(count) << 8) | {30'd0, done, 1'b0};
  endfunction

endpackage

// File: rtl/wbs_kdtree_node_loader.sv
// Wishbone classic slave that loads KD-tree internal nodes into node memory.
// Offset 0 of the window is STATUS, offsets 1..NUM_NODES map to node slots 0..NUM_NODES-1.
// Optional feature macro: NODE_LOADER_RDBACK_EN -- when defined, node-slot reads
// go through node_ren/node_rdata (two-cycle read); otherwise node_ren is tied low
// and node-slot reads return the last accepted node word in one cycle.
module wbs_kdtree_node_loader
  import kdtree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KD_DATA_WIDTH,
  parameter int unsigned NUM_NODES  = KD_NUM_NODES,
  parameter int unsigned NODE_AW    = KD_NODE_AW,
  parameter logic [31:0] BASE_ADDR  = WBS_NODE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_en,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    node_wen,
  output logic [NODE_AW-1:0]      node_addr,
  output logic [2*DATA_WIDTH-1:0] node_wdata,
  output logic                    node_ren,
  input  logic [2*DATA_WIDTH-1:0] node_rdata,
  output logic [NODE_AW-1:0]      node_count,
  output logic                    load_done
);

  localparam logic [NODE_AW-1:0] COUNT_MAX = NODE_AW'(NUM_NODES);
  localparam logic [31:0]        WINDOW    = 32'(NUM_NODES) + 32'd1;
  localparam int unsigned        PAD_W     = 32 - 2*DATA_WIDTH;

  wbs_state_e              state_r;
  logic [31:0]             off_s;
  logic                    hit_s;
  logic                    is_status_s;
  logic                    wr_ok_s;
  logic [NODE_AW-1:0]      slot_s;
  logic [2*DATA_WIDTH-1:0] node_s;

  // Address decode and write qualification for the request currently on the bus
  always_comb begin
    off_s       = wbs_adr_i - BASE_ADDR;
    hit_s       = wbs_cyc_i && wbs_stb_i && (off_s < WINDOW);
    is_status_s = (off_s == STATUS_OFF);
    slot_s      = off_s[NODE_AW-1:0] - NODE_AW'(1);
    wr_ok_s     = load_en && (wbs_sel_i[2:0] == 3'b111);
    node_s      = decode_node(wbs_dat_i[2*DATA_WIDTH-1:0]);
  end

`ifdef NODE_LOADER_RDBACK_EN
  logic unused_s;
  assign unused_s = ^{wbs_sel_i[3], wbs_dat_i[31:2*DATA_WIDTH]};
`else
  // Without readback the memory read port is never used
  logic unused_s;
  assign unused_s = ^{wbs_sel_i[3], wbs_dat_i[31:2*DATA_WIDTH], node_rdata};
  assign node_ren = 1'b0;
`endif

  // Request FSM, node write/read strobes, load counter and bus response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'd0;
      node_wen   <= 1'b0;
      node_addr  <= '0;
      node_wdata <= '0;
      node_count <= '0;
      load_done  <= 1'b0;
`ifdef NODE_LOADER_RDBACK_EN
      node_ren   <= 1'b0;
`endif
    end else begin
      wbs_ack_o <= 1'b0;
      node_wen  <= 1'b0;
`ifdef NODE_LOADER_RDBACK_EN
      node_ren  <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            if (wbs_we_i) begin
              state_r   <= ST_RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= 32'd0;
              if (is_status_s) begin
                if (wbs_dat_i[0]) begin
                  node_count <= '0;
                  load_done  <= 1'b0;
                end
              end else if (wr_ok_s) begin
                node_wen   <= 1'b1;
                node_addr  <= slot_s;
                node_wdata <= node_s;
                // A rewritten slot still counts; the master sends each node once
                if (node_count != COUNT_MAX) begin
                  node_count <= node_count + NODE_AW'(1);
                  load_done  <= ((node_count + NODE_AW'(1)) == COUNT_MAX);
                end
              end
            end else if (is_status_s) begin
              state_r   <= ST_RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= status_word(node_count, load_done);
            end else begin
`ifdef NODE_LOADER_RDBACK_EN
              state_r   <= ST_RD_WAIT;
              node_ren  <= 1'b1;
              node_addr <= slot_s;
`else
              // node_wdata only changes on accepted writes, so it doubles as
              // the shadow of the last accepted node word
              state_r   <= ST_RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= {{PAD_W{1'b0}}, node_wdata};
`endif
            end
          end
        end
`ifdef NODE_LOADER_RDBACK_EN
        ST_RD_WAIT: begin
          // A master that drops cyc/stb here abandons the read without an ack
          if (wbs_cyc_i && wbs_stb_i) begin
            state_r   <= ST_RESP;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= {{PAD_W{1'b0}}, node_rdata};
          end else begin
            state_r <= ST_IDLE;
          end
        end
`endif
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_kdtree_node_loader.sv
// Scoreboard bench for wbs_kdtree_node_loader: a bus driver pushes expected
// responses/node writes computed from a slot-level model, and monitors pop and
// compare them whenever the DUT acks or strobes node_wen.
module tb_wbs_kdtree_node_loader;

  localparam int          DW   = 11;
  localparam int          NN   = 63;
  localparam int          AW   = 6;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'd0;
  logic [31:0]   dati = 32'd0;
  logic          ack;
  logic [31:0]   dato;
  logic          node_wen;
  logic          node_ren;
  logic [AW-1:0] node_addr;
  logic [2*DW-1:0] node_wdata;
  logic [2*DW-1:0] node_rdata;
  logic [AW-1:0] node_count;
  logic          load_done;

  int tests = 0;
  int fails = 0;

  wbs_kdtree_node_loader dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dati), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .node_wen(node_wen), .node_addr(node_addr), .node_wdata(node_wdata),
    .node_ren(node_ren), .node_rdata(node_rdata),
    .node_count(node_count), .load_done(load_done)
  );

  always #5 clk = ~clk;

  // Node memory seen by the DUT (not reset, like a real RAM)
  logic [2*DW-1:0] tbmem [0:63];
  initial for (int i = 0; i < 64; i++) tbmem[i] = '0;
  always @(posedge clk) if (node_wen) tbmem[node_addr] <= node_wdata;
  assign node_rdata = tbmem[node_addr];

  // Reference model state
  int              m_count = 0;
  logic [2*DW-1:0] m_last = '0;
  logic [2*DW-1:0] m_slot [0:NN-1];
  initial for (int i = 0; i < NN; i++) m_slot[i] = '0;

  logic [31:0]       exp_data_q[$];
  bit                exp_chk_q[$];
  logic [AW+2*DW-1:0] exp_wen_q[$];
  int                ack_seen = 0;
  bit                prev_held = 1'b0;

  logic [31:0]        mon_e;
  bit                 mon_c;
  logic [AW+2*DW-1:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Ack monitor: every ack must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n && ack === 1'b1) begin
      ack_seen++;
      if (exp_data_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = exp_data_q.pop_front();
        mon_c = exp_chk_q.pop_front();
        if (mon_c) check("ack_data", dato, mon_e);
      end
    end
  end

  // Node write monitor: every node_wen pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && node_wen === 1'b1) begin
      if (exp_wen_q.size() == 0) begin
        check("unexpected_node_wen", 32'd1, 32'd0);
      end else begin
        mon_w = exp_wen_q.pop_front();
        check("node_write", 32'({node_addr, node_wdata}), 32'(mon_w));
      end
    end
  end

  // One Wishbone access, starting and ending on a falling edge
  task automatic wb(input logic [31:0] a, input bit w, input logic [3:0] s,
                    input logic [31:0] d, input bit hold);
    logic [31:0] off;
    bit          hit;
    int          lat;
    bit          got;
    int          exp_lat;
    off     = a - BASE;
    hit     = (off < 32'd64);
    exp_lat = 1;
    if (hit) begin
      if (w) begin
        exp_data_q.push_back(32'd0);
        exp_chk_q.push_back(1'b0);
        if (off == 32'd0) begin
          if (d[0]) m_count = 0;
        end else if (load_en && s[2:0] == 3'b111) begin
          exp_wen_q.push_back({AW'(off - 32'd1), d[2*DW-1:0]});
          m_slot[off - 32'd1] = d[2*DW-1:0];
          m_last = d[2*DW-1:0];
          if (m_count < NN) m_count++;
        end
      end else if (off == 32'd0) begin
        exp_data_q.push_back((32'(m_count) << 8) | ((m_count == NN) ? 32'd2 : 32'd0));
        exp_chk_q.push_back(1'b1);
      end else begin
`ifdef NODE_LOADER_RDBACK_EN
        exp_data_q.push_back(32'(m_slot[off - 32'd1]));
        exp_lat = 2;
`else
        exp_data_q.push_back(32'(m_last));
`endif
        exp_chk_q.push_back(1'b1);
      end
    end
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dati = d;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ack === 1'b1) got = 1'b1;
    end
    if (hit) begin
      check("ack_received", 32'(got), 32'd1);
      if (got && !prev_held) check("ack_latency", 32'(lat), 32'(exp_lat));
    end else begin
      check("miss_no_ack", 32'(got), 32'd0);
    end
    prev_held = hold;
    if (!hold) begin
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check("node_count", 32'(node_count), 32'(m_count));
      check("load_done", 32'(load_done), (m_count == NN) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ack"},        32'(ack),        32'd0);
    check({tag, "_dat_o"},      dato,            32'd0);
    check({tag, "_node_wen"},   32'(node_wen),   32'd0);
    check({tag, "_node_ren"},   32'(node_ren),   32'd0);
    check({tag, "_node_addr"},  32'(node_addr),  32'd0);
    check({tag, "_node_wdata"}, 32'(node_wdata), 32'd0);
    check({tag, "_node_count"}, 32'(node_count), 32'd0);
    check({tag, "_load_done"},  32'(load_done),  32'd0);
  endtask

  task automatic load_all();
    logic [31:0] r;
    for (int i = 1; i <= NN; i++) begin
      r = $urandom;
      wb(BASE + 32'(i), 1'b1, 4'hF, {r[31:22], 11'd55, 11'(i)}, 1'b0);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] r;
    logic [3:0]  s;
    bit          w;
    bit          h;
    int          kind;
    int          n0;

    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full load of all internal nodes
    load_en = 1'b1;
    load_all();
    check("full_load_done", 32'(load_done), 32'd1);

    // STATUS read after a full load
    wb(BASE, 1'b0, 4'hF, 32'd0, 1'b0);

    // Write then read of the same slot with cyc/stb held through
    wb(BASE + 32'd5, 1'b1, 4'hF, 32'h001B_8001, 1'b1);
    wb(BASE + 32'd5, 1'b0, 4'hF, 32'd0, 1'b0);

    // Rejected writes: load_en low, partial byte selects
    load_en = 1'b0;
    wb(BASE + 32'd7, 1'b1, 4'hF, 32'h0012_3456, 1'b0);
    load_en = 1'b1;
    wb(BASE + 32'd8, 1'b1, 4'b0001, 32'h0034_5678, 1'b0);

    // STATUS clear, then a STATUS read shows zero
    wb(BASE, 1'b1, 4'hF, 32'd1, 1'b0);
    wb(BASE, 1'b0, 4'hF, 32'd0, 1'b0);

    // Misses just past the window and below it
    wb(BASE + 32'd64, 1'b1, 4'hF, 32'h0000_0FFF, 1'b0);
    wb(BASE + 32'd64, 1'b0, 4'hF, 32'd0, 1'b0);
    wb(BASE - 32'd4, 1'b1, 4'hF, 32'h0000_0FFF, 1'b0);

`ifdef NODE_LOADER_RDBACK_EN
    // Abandon a node read while it waits on memory
    n0 = ack_seen;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'd3;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    repeat (4) @(negedge clk);
    check("abandon_no_ack", 32'(ack_seen - n0), 32'd0);
    wb(BASE + 32'd3, 1'b0, 4'hF, 32'd0, 1'b0);
`endif

    // Randomised mix of node writes, reads, STATUS accesses and misses
    for (int n = 0; n < 300; n++) begin
      kind    = $urandom_range(0, 9);
      load_en = ($urandom_range(0, 4) != 0);
      r       = $urandom;
      s       = ($urandom_range(0, 3) != 0) ? 4'hF : r[3:0];
      d       = $urandom;
      w       = ($urandom_range(0, 1) == 1);
      h       = ($urandom_range(0, 2) == 0);
      if (kind == 0) begin
        a = BASE + 32'd64 + 32'($urandom_range(0, 255));
        h = 1'b0;
      end else if (kind == 1) begin
        a = BASE;
        if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
      end else begin
        a = BASE + 32'($urandom_range(1, NN));
      end
      wb(a, w, s, d, h);
    end
    if (prev_held) begin
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      prev_held = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of the 30th write of a fresh load
    load_en = 1'b1;
    wb(BASE, 1'b1, 4'hF, 32'd1, 1'b0);
    for (int i = 1; i < 30; i++) wb(BASE + 32'(i), 1'b1, 4'hF, 32'(i), 1'b0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'd30; dati = 32'd30;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    exp_data_q.delete();
    exp_chk_q.delete();
    exp_wen_q.delete();
    m_count = 0;
    m_last  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_held = 1'b0;
    @(negedge clk);

    // Reload after reset completes
    load_all();
    check("reload_done", 32'(load_done), 32'd1);
    wb(BASE + 32'd30, 1'b0, 4'hF, 32'd0, 1'b0);

    repeat (4) @(negedge clk);
    check("ack_queue_drained", 32'(exp_data_q.size()), 32'd0);
    check("wen_queue_drained", 32'(exp_wen_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
